// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the RISC-V decode stage:
//   - fmt_t        : instruction format codes (R/I/S/B/U/J/ILL)
//   - OPC_*        : major opcode constants (ins[6:0])
//   - skid_state_t : occupancy of the output register / skid buffer pair
//   - dec_fields_t : XLEN-independent part of the decoded bundle
// The XLEN-wide members (pc, imm) are added by the stage itself, since a
// package typedef cannot depend on a module parameter.
// -----------------------------------------------------------------------------
package rv_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_t;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    // EMPTY: nothing held; ONE: output register full; TWO: output + skid full.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [6:0] funct7;
        fmt_t       fmt;
        logic       illegal;
    } dec_fields_t;

endpackage

// File: rtl/rv_imm_gen.sv
// -----------------------------------------------------------------------------
// rv_imm_gen
// Purely combinational: classifies the instruction format from the opcode,
// flags undecodable instructions and assembles the sign-extended immediate.
// Parameters:
//   XLEN       : 32 or 64, width of the produced immediate
// Ports:
//   i_ins      : raw 32-bit instruction
//   o_fmt      : format code (R=0, I=1, S=2, B=3, U=4, J=5, ILL=7)
//   o_imm      : immediate for o_fmt, sign-extended from ins[31]; 0 for R/ILL
//   o_illegal  : high when the instruction is not decodable
// -----------------------------------------------------------------------------
module rv_imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_ins,
    output logic [2:0]      o_fmt,
    output logic [XLEN-1:0] o_imm,
    output logic            o_illegal
);

    logic [6:0] w_opcode;
    logic       w_sign;
    fmt_t       w_fmt;
    logic [XLEN-1:0] w_imm;

    assign w_opcode = i_ins[6:0];
    assign w_sign   = i_ins[31];

    // Format detection. The *_32 opcodes only exist on RV64.
    always_comb begin
        w_fmt = FMT_ILL;
        if (i_ins[1:0] == 2'b11) begin
            case (w_opcode)
                OPC_OP:        w_fmt = FMT_R;
                OPC_OP_IMM,
                OPC_LOAD,
                OPC_JALR,
                OPC_SYSTEM,
                OPC_MISC_MEM:  w_fmt = FMT_I;
                OPC_STORE:     w_fmt = FMT_S;
                OPC_BRANCH:    w_fmt = FMT_B;
                OPC_LUI,
                OPC_AUIPC:     w_fmt = FMT_U;
                OPC_JAL:       w_fmt = FMT_J;
                OPC_OP_IMM_32: w_fmt = (XLEN == 64) ? FMT_I : FMT_ILL;
                OPC_OP_32:     w_fmt = (XLEN == 64) ? FMT_R : FMT_ILL;
                default:       w_fmt = FMT_ILL;
            endcase
        end
    end

    // Immediate assembly. ins[31] is both the top payload bit and the sign,
    // so each pattern replicates it and then appends the remaining bits;
    // the replication counts stay >= 1 for XLEN=32.
    always_comb begin
        w_imm = '0;
        case (w_fmt)
            FMT_I: w_imm = {{(XLEN-11){w_sign}}, i_ins[30:20]};
            FMT_S: w_imm = {{(XLEN-11){w_sign}}, i_ins[30:25], i_ins[11:7]};
            FMT_B: w_imm = {{(XLEN-12){w_sign}}, i_ins[7], i_ins[30:25],
                            i_ins[11:8], 1'b0};
            FMT_U: w_imm = {{(XLEN-31){w_sign}}, i_ins[30:12], 12'b0};
            FMT_J: w_imm = {{(XLEN-20){w_sign}}, i_ins[19:12], i_ins[20],
                            i_ins[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    assign o_fmt     = w_fmt;
    assign o_imm     = w_imm;
    assign o_illegal = (w_fmt == FMT_ILL);

endmodule

// File: rtl/rv_decode_stage.sv
// -----------------------------------------------------------------------------
// rv_decode_stage
// Registered RISC-V decode stage between fetch and register read, with
// valid/ready handshakes on both sides. Decode happens combinationally on
// in_ins; the decoded bundle (fields, format, immediate, pc) is registered.
// Parameters:
//   XLEN : 32 or 64, width of pc and immediate
//   SKID : 0 = single output register, in_ready combinational
//          1 = output register + skid entry, in_ready from a flop
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : upstream handshake
//   in_ins, in_pc        : raw instruction and its address
//   out_valid / out_ready: downstream handshake
//   out_pc               : registered pc
//   out_opcode..funct7   : raw instruction fields, passed through unmodified
//   out_fmt, out_imm     : format code and sign-extended immediate
//   out_illegal          : instruction not decodable
// -----------------------------------------------------------------------------
module rv_decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ins,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [6:0]      out_funct7,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        dec_fields_t     f;
    } bundle_t;

    logic [2:0]      w_fmt;
    logic [XLEN-1:0] w_imm;
    logic            w_illegal;
    bundle_t         w_dec;
    bundle_t         w_out;
    logic            w_out_valid;
    logic            w_in_ready;

    rv_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .i_ins     (in_ins),
        .o_fmt     (w_fmt),
        .o_imm     (w_imm),
        .o_illegal (w_illegal)
    );

    always_comb begin
        w_dec           = '0;
        w_dec.pc        = in_pc;
        w_dec.imm       = w_imm;
        w_dec.f.opcode  = in_ins[6:0];
        w_dec.f.rd      = in_ins[11:7];
        w_dec.f.funct3  = in_ins[14:12];
        w_dec.f.rs1     = in_ins[19:15];
        w_dec.f.rs2     = in_ins[24:20];
        w_dec.f.funct7  = in_ins[31:25];
        w_dec.f.fmt     = fmt_t'(w_fmt);
        w_dec.f.illegal = w_illegal;
    end

    if (SKID == 0) begin : g_single
        bundle_t r_out;
        logic    r_out_valid;
        logic    w_in_xfer;

        // Gated by rst so nothing is accepted while the stage is held in reset.
        assign w_in_ready = !rst && (!r_out_valid || out_ready);
        assign w_in_xfer  = in_valid && w_in_ready;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_out       <= '0;
                r_out_valid <= 1'b0;
            end else if (w_in_xfer) begin
                r_out       <= w_dec;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end

        assign w_out       = r_out;
        assign w_out_valid = r_out_valid;
    end else begin : g_skid
        skid_state_t r_state;
        skid_state_t w_state_next;
        bundle_t     r_out;
        bundle_t     r_skid;
        logic        r_in_ready;
        logic        w_in_xfer;
        logic        w_out_xfer;
        logic        w_load_from_in;
        logic        w_load_from_skid;
        logic        w_load_skid;

        // r_in_ready resets to 1 so the first edge after release can accept;
        // the rst gate keeps in_ready low for the whole reset interval.
        assign w_in_ready = r_in_ready && !rst;
        assign w_in_xfer  = in_valid && w_in_ready;
        assign w_out_xfer = (r_state != ST_EMPTY) && out_ready;

        // State register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= ST_EMPTY;
            end else begin
                r_state <= w_state_next;
            end
        end

        // Next-state logic
        always_comb begin
            w_state_next = r_state;
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) w_state_next = ST_ONE;
                end
                ST_ONE: begin
                    if (w_in_xfer && !w_out_xfer)      w_state_next = ST_TWO;
                    else if (!w_in_xfer && w_out_xfer) w_state_next = ST_EMPTY;
                end
                ST_TWO: begin
                    if (w_out_xfer) w_state_next = ST_ONE;
                end
                default: w_state_next = ST_EMPTY;
            endcase
        end

        // Output logic: datapath load enables per state
        always_comb begin
            w_load_from_in   = 1'b0;
            w_load_from_skid = 1'b0;
            w_load_skid      = 1'b0;
            case (r_state)
                ST_EMPTY: w_load_from_in = w_in_xfer;
                ST_ONE: begin
                    // A stalled output keeps its bundle; the newcomer parks in the skid.
                    w_load_from_in = w_in_xfer && w_out_xfer;
                    w_load_skid    = w_in_xfer && !w_out_xfer;
                end
                ST_TWO:   w_load_from_skid = w_out_xfer;
                default: begin
                    w_load_from_in   = 1'b0;
                    w_load_from_skid = 1'b0;
                    w_load_skid      = 1'b0;
                end
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_out      <= '0;
                r_skid     <= '0;
                r_in_ready <= 1'b1;
            end else begin
                r_in_ready <= (w_state_next != ST_TWO);
                if (w_load_from_in) begin
                    r_out <= w_dec;
                end else if (w_load_from_skid) begin
                    r_out <= r_skid;
                end
                if (w_load_skid) begin
                    r_skid <= w_dec;
                end
            end
        end

        assign w_out       = r_out;
        assign w_out_valid = (r_state != ST_EMPTY);
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = w_out_valid;
    assign out_pc      = w_out.pc;
    assign out_imm     = w_out.imm;
    assign out_opcode  = w_out.f.opcode;
    assign out_rd      = w_out.f.rd;
    assign out_funct3  = w_out.f.funct3;
    assign out_rs1     = w_out.f.rs1;
    assign out_rs2     = w_out.f.rs2;
    assign out_funct7  = w_out.f.funct7;
    assign out_fmt     = w_out.f.fmt;
    assign out_illegal = w_out.f.illegal;

endmodule
